// File: rtl/wb_pkg.sv
// Shared types and helpers for the register-bank writeback sequencer.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        WRITE   = 2'd2
    } wb_state_t;

    localparam logic [3:0] VREG_BASE = 4'd12;
    localparam int         V_DEFAULT = 128;
    localparam int         N_DEFAULT = 32;
    localparam int         LANES     = V_DEFAULT / N_DEFAULT;

    function automatic logic is_vreg(input logic [3:0] addr);
        return addr >= VREG_BASE;
    endfunction

endpackage

// File: rtl/vec_beat_assembler.sv
// Collects 32-bit load beats into lanes of a vector-wide buffer; done pulses
// combinationally on the beat that fills the final expected lane.
module vec_beat_assembler
    import wb_pkg::*;
#(
    parameter int V = 128,
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         start_vec,
    input  logic         beat_valid,
    input  logic [N-1:0] beat_data,
    input  logic         clear,
    output logic         done,
    output logic [V-1:0] data
);

    localparam int NL = V / N;
    localparam int CW = (NL > 1) ? $clog2(NL) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] last_q, last_d;

    assign done = beat_valid && (cnt_q == last_q);

    always_comb begin
        cnt_d  = cnt_q;
        last_d = last_q;
        if (start) begin
            cnt_d  = '0;
            last_d = start_vec ? CW'(NL - 1) : '0;
        end else if (beat_valid && !done) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            last_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            last_q <= last_d;
        end
    end

    // Lanes never written by a scalar load stay zero because the buffer is
    // cleared after every load write.
    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_lane
            logic [N-1:0] lane_q, lane_d;

            always_comb begin
                lane_d = lane_q;
                if (clear) begin
                    lane_d = '0;
                end else if (beat_valid && (cnt_q == CW'(gi))) begin
                    lane_d = beat_data;
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    lane_q <= '0;
                end else begin
                    lane_q <= lane_d;
                end
            end

            assign data[gi*N +: N] = lane_q;
        end
    endgenerate

endmodule

// File: rtl/reg_writeback_seq.sv
// Sole driver of the register bank write port: arbitrates execute results
// against assembled memory loads and tracks registers with loads in flight.
module reg_writeback_seq
    import wb_pkg::*;
#(
    parameter int V = 128,
    parameter int N = 32,
    parameter int M = 4
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    output logic            ex_ready,
    input  logic [M-1:0]    ex_addr,
    input  logic [V-1:0]    ex_data,
    input  logic            ld_req_valid,
    output logic            ld_req_ready,
    input  logic [M-1:0]    ld_req_addr,
    input  logic            ld_beat_valid,
    input  logic [N-1:0]    ld_beat_data,
    output logic            we3,
    output logic [M-1:0]    wa3,
    output logic [V-1:0]    wd3,
    output logic [2**M-1:0] busy,
    output logic            ld_err
);

    localparam int R = 2**M;

    wb_state_t      state_q, state_d;
    logic [M-1:0]   dest_q, dest_d;
    logic [R-1:0]   busy_q, busy_d;
    logic           ld_err_q, ld_err_d;
    logic           we3_q, we3_d;
    logic [M-1:0]   wa3_q, wa3_d;
    logic [V-1:0]   wd3_q, wd3_d;
    logic           wr_load_q, wr_load_d;

    logic           ld_start;
    logic           ld_start_vec;
    logic           beat_take;
    logic           asm_clear;
    logic           asm_done;
    logic [V-1:0]   asm_data;

    assign ld_req_ready = (state_q == IDLE);
    assign ex_ready     = (state_q != WRITE) && !busy_q[ex_addr];
    assign ld_start     = (state_q == IDLE) && ld_req_valid;
    assign ld_start_vec = is_vreg(ld_req_addr);
    assign beat_take    = (state_q == COLLECT) && ld_beat_valid;
    assign asm_clear    = (state_q == WRITE);

    vec_beat_assembler #(
        .V (V),
        .N (N)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .start      (ld_start),
        .start_vec  (ld_start_vec),
        .beat_valid (beat_take),
        .beat_data  (ld_beat_data),
        .clear      (asm_clear),
        .done       (asm_done),
        .data       (asm_data)
    );

    always_comb begin
        state_d   = state_q;
        dest_d    = dest_q;
        busy_d    = busy_q;
        ld_err_d  = ld_err_q | (ld_beat_valid && (state_q != COLLECT));
        we3_d     = 1'b0;
        wa3_d     = wa3_q;
        wd3_d     = wd3_q;
        wr_load_d = 1'b0;

        // Release the reservation only once the bank already holds the value.
        if (we3_q && wr_load_q) begin
            busy_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (ld_req_valid) begin
                    dest_d              = ld_req_addr;
                    busy_d[ld_req_addr] = 1'b1;
                    state_d             = COLLECT;
                end
            end
            COLLECT: begin
                if (asm_done) begin
                    state_d = WRITE;
                end
            end
            WRITE: begin
                state_d   = IDLE;
                we3_d     = 1'b1;
                wa3_d     = dest_q;
                wd3_d     = asm_data;
                wr_load_d = 1'b1;
            end
            default: state_d = IDLE;
        endcase

        // ex_ready is low in WRITE, so this never collides with a load write.
        if (ex_valid && ex_ready) begin
            we3_d = 1'b1;
            wa3_d = ex_addr;
            wd3_d = is_vreg(ex_addr) ? ex_data : {{(V-N){1'b0}}, ex_data[N-1:0]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            dest_q    <= '0;
            busy_q    <= '0;
            ld_err_q  <= 1'b0;
            we3_q     <= 1'b0;
            wa3_q     <= '0;
            wd3_q     <= '0;
            wr_load_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dest_q    <= dest_d;
            busy_q    <= busy_d;
            ld_err_q  <= ld_err_d;
            we3_q     <= we3_d;
            wa3_q     <= wa3_d;
            wd3_q     <= wd3_d;
            wr_load_q <= wr_load_d;
        end
    end

    assign we3    = we3_q;
    assign wa3    = wa3_q;
    assign wd3    = wd3_q;
    assign busy   = busy_q;
    assign ld_err = ld_err_q;

endmodule
